// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_arbiter_if : icache/dcache/memory line-port bundle             |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) ();
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic [LINE_W-1:0] ic_rdata;
  logic              ic_ack;

  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [LINE_W-1:0] dc_wdata;
  logic [LINE_W-1:0] dc_rdata;
  logic              dc_ack;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ack;

  // Arbiter side
  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata, mem_ack,
    output ic_rdata, ic_ack, dc_rdata, dc_ack, mem_req, mem_we, mem_addr, mem_wdata
  );

  // Environment side (caches and memory)
  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata, mem_ack,
    input  ic_rdata, ic_ack, dc_rdata, dc_ack, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_arbiter : round-robin share of one memory line port between    |
// |               icache fills and dcache fills/write-backs            |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int CNT_W  = 16
) (
  input  wire              clk,
  input  wire              reset,
  mem_arbiter_if.slave     bus,
  output logic             busy,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT_I = 2'd1,
    S_GRANT_D = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t            state_q;
  logic              last_dc_q;
  logic [CNT_W-1:0]  conflict_q;
  logic [CNT_W-1:0]  conflict_d;
  logic              contend_d;
  logic              pick_dc_d;

  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_wdata_q;
  logic              ic_ack_q;
  logic              dc_ack_q;
  logic [LINE_W-1:0] ic_rdata_q;
  logic [LINE_W-1:0] dc_rdata_q;
  logic              busy_q;

  // Under contention the side that did not win last time is chosen.
  always_comb begin
    contend_d  = bus.ic_req && bus.dc_req;
    pick_dc_d  = contend_d ? !last_dc_q : bus.dc_req;
    conflict_d = conflict_q;
    if (contend_d && (conflict_q != {CNT_W{1'b1}})) begin
      conflict_d = conflict_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      last_dc_q   <= 1'b0;
      conflict_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ic_ack_q    <= 1'b0;
      dc_ack_q    <= 1'b0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          conflict_q <= conflict_d;
          if (bus.ic_req || bus.dc_req) begin
            mem_req_q <= 1'b1;
            busy_q    <= 1'b1;
            last_dc_q <= pick_dc_d;
            if (pick_dc_d) begin
              state_q     <= S_GRANT_D;
              mem_addr_q  <= bus.dc_addr;
              mem_we_q    <= bus.dc_we;
              mem_wdata_q <= bus.dc_wdata;
            end else begin
              state_q     <= S_GRANT_I;
              mem_addr_q  <= bus.ic_addr;
              mem_we_q    <= 1'b0;
              mem_wdata_q <= '0;
            end
          end
        end
        S_GRANT_I, S_GRANT_D: begin
          if (bus.mem_ack) begin
            state_q   <= S_RESP;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (state_q == S_GRANT_D) begin
              dc_ack_q   <= 1'b1;
              dc_rdata_q <= bus.mem_rdata;
            end else begin
              ic_ack_q   <= 1'b1;
              ic_rdata_q <= bus.mem_rdata;
            end
          end
        end
        S_RESP: begin
          state_q    <= S_IDLE;
          ic_ack_q   <= 1'b0;
          dc_ack_q   <= 1'b0;
          ic_rdata_q <= '0;
          dc_rdata_q <= '0;
          busy_q     <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.ic_ack    = ic_ack_q;
  assign bus.dc_ack    = dc_ack_q;
  assign bus.ic_rdata  = ic_rdata_q;
  assign bus.dc_rdata  = dc_rdata_q;
  assign busy          = busy_q;
  assign conflict_cnt  = conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// Bench for mem_arbiter: directed cycle table, randomized traffic against a
// transaction-level reference, and counter saturation on a narrow instance.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;
  localparam int CNT_W  = 16;
  localparam int SAT_W  = 3;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam logic [ADDR_W-1:0] IA = 32'h40;
  localparam logic [ADDR_W-1:0] DA = 32'h80;
  localparam logic [LINE_W-1:0] WD = 128'h1234;
  localparam logic [LINE_W-1:0] RD = {4{32'hAAAA_AAAA}};

  logic clk = 1'b0;
  logic rst;
  logic srst;
  logic busy;
  logic sbusy;
  logic [CNT_W-1:0] cnt;
  logic [SAT_W-1:0] scnt;
  int tests = 0;
  int fails = 0;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();
  mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) sbus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(rst), .bus(bus.slave), .busy(busy), .conflict_cnt(cnt)
  );
  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(SAT_W)) u_sat (
    .clk(clk), .reset(srst), .bus(sbus.slave), .busy(sbusy), .conflict_cnt(scnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, icr, dcr, we, mack;
    logic e_req, e_we;
    logic [ADDR_W-1:0] e_addr;
    logic e_wd, e_ia, e_da, e_busy;
    int   e_cnt;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic r, ic, dc, w, a, q, qw,
                              input logic [ADDR_W-1:0] ad,
                              input logic wd, ia, da, b, input int c);
    vec_t v;
    v.rst = r; v.icr = ic; v.dcr = dc; v.we = w; v.mack = a;
    v.e_req = q; v.e_we = qw; v.e_addr = ad; v.e_wd = wd;
    v.e_ia = ia; v.e_da = da; v.e_busy = b; v.e_cnt = c;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference: a transaction either owns the port, is being acknowledged,
  // or the port is free and the next owner is chosen from pending requests.
  int m_owner;                // 0 none, 1 icache, 2 dcache
  bit m_resp;
  bit m_last_dc;
  int m_cnt;
  logic e_req, e_we, e_ia, e_da, e_busy;
  logic [ADDR_W-1:0] e_addr;
  logic [LINE_W-1:0] e_wd, e_ird, e_drd;

  task automatic model_step();
    if (rst) begin
      m_owner = 0; m_resp = 0; m_last_dc = 0; m_cnt = 0;
      e_req = 0; e_we = 0; e_addr = '0; e_wd = '0;
      e_ia = 0; e_da = 0; e_ird = '0; e_drd = '0; e_busy = 0;
    end else if (m_resp) begin
      m_resp = 0; e_ia = 0; e_da = 0; e_ird = '0; e_drd = '0; e_busy = 0;
    end else if (m_owner != 0) begin
      if (bus.mem_ack) begin
        e_req = 0; e_we = 0; m_resp = 1;
        if (m_owner == 2) begin e_da = 1; e_drd = bus.mem_rdata; end
        else begin e_ia = 1; e_ird = bus.mem_rdata; end
        m_owner = 0;
      end
    end else if (bus.ic_req || bus.dc_req) begin
      if (bus.ic_req && bus.dc_req) begin
        m_owner = m_last_dc ? 1 : 2;
        if (m_cnt < CMAX) m_cnt++;
      end else begin
        m_owner = bus.dc_req ? 2 : 1;
      end
      m_last_dc = (m_owner == 2);
      e_req = 1; e_busy = 1;
      if (m_owner == 2) begin e_addr = bus.dc_addr; e_we = bus.dc_we; e_wd = bus.dc_wdata; end
      else begin e_addr = bus.ic_addr; e_we = 0; e_wd = '0; end
    end
  endtask

  initial begin
    rst = 1'b1;
    srst = 1'b1;
    bus.ic_req = 0; bus.ic_addr = IA;
    bus.dc_req = 0; bus.dc_we = 0; bus.dc_addr = DA; bus.dc_wdata = WD;
    bus.mem_ack = 0; bus.mem_rdata = RD;
    sbus.ic_req = 1; sbus.ic_addr = IA;
    sbus.dc_req = 1; sbus.dc_we = 0; sbus.dc_addr = DA; sbus.dc_wdata = WD;
    sbus.mem_ack = 1; sbus.mem_rdata = RD;

    //   rst ic dc we ack | req we addr wd ia da busy cnt
    add(1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0,  1, 0, IA, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0,  1, 0, IA, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0,  1, 0, IA, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 1,  0, 0, IA, 0, 1, 0, 1, 0);
    add(0, 1, 0, 0, 0,  0, 0, IA, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0,  0, 0, IA, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1,  0, 0, IA, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0,  1, 1, DA, 1, 0, 0, 1, 0);
    add(0, 0, 1, 1, 0,  1, 1, DA, 1, 0, 0, 1, 0);
    add(0, 0, 1, 1, 1,  0, 0, DA, 1, 0, 1, 1, 0);
    add(0, 0, 1, 1, 0,  0, 0, DA, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0,  0, 0, DA, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0,  1, 0, DA, 1, 0, 0, 1, 1);
    add(0, 1, 1, 0, 1,  0, 0, DA, 1, 0, 1, 1, 1);
    add(0, 1, 1, 0, 0,  0, 0, DA, 1, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0,  1, 0, IA, 0, 0, 0, 1, 1);
    add(0, 1, 0, 0, 1,  0, 0, IA, 0, 1, 0, 1, 1);
    add(0, 1, 0, 0, 0,  0, 0, IA, 0, 0, 0, 0, 1);
    add(0, 1, 1, 1, 0,  1, 1, DA, 1, 0, 0, 1, 2);
    add(0, 1, 1, 1, 1,  0, 0, DA, 1, 0, 1, 1, 2);
    add(0, 1, 1, 1, 0,  0, 0, DA, 1, 0, 0, 0, 2);
    add(0, 1, 1, 0, 0,  1, 0, IA, 0, 0, 0, 1, 3);
    add(0, 1, 1, 0, 1,  0, 0, IA, 0, 1, 0, 1, 3);
    add(0, 1, 1, 0, 0,  0, 0, IA, 0, 0, 0, 0, 3);
    add(0, 0, 1, 0, 0,  1, 0, DA, 1, 0, 0, 1, 3);
    add(0, 0, 1, 0, 0,  1, 0, DA, 1, 0, 0, 1, 3);
    add(1, 0, 1, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0,  1, 0, DA, 1, 0, 0, 1, 0);
    add(0, 0, 1, 0, 1,  0, 0, DA, 1, 0, 1, 1, 0);
    add(0, 0, 1, 0, 0,  0, 0, DA, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0,  0, 0, DA, 1, 0, 0, 0, 0);

    @(negedge clk);
    foreach (tbl[i]) begin
      rst = tbl[i].rst; bus.ic_req = tbl[i].icr; bus.dc_req = tbl[i].dcr;
      bus.dc_we = tbl[i].we; bus.mem_ack = tbl[i].mack;
      @(negedge clk);
      chk($sformatf("v%0d mem_req", i), bus.mem_req, tbl[i].e_req);
      chk($sformatf("v%0d mem_we", i), bus.mem_we, tbl[i].e_we);
      chk($sformatf("v%0d mem_addr", i), bus.mem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata, tbl[i].e_wd ? WD : {LINE_W{1'b0}});
      chk($sformatf("v%0d ic_ack", i), bus.ic_ack, tbl[i].e_ia);
      chk($sformatf("v%0d dc_ack", i), bus.dc_ack, tbl[i].e_da);
      chk($sformatf("v%0d ic_rdata", i), bus.ic_rdata, tbl[i].e_ia ? RD : {LINE_W{1'b0}});
      chk($sformatf("v%0d dc_rdata", i), bus.dc_rdata, tbl[i].e_da ? RD : {LINE_W{1'b0}});
      chk($sformatf("v%0d busy", i), busy, tbl[i].e_busy);
      chk($sformatf("v%0d conflict_cnt", i), cnt, tbl[i].e_cnt[CNT_W-1:0]);
    end

    // Randomized traffic, with occasional resets and stray memory acks
    rst = 1; bus.ic_req = 0; bus.dc_req = 0; bus.mem_ack = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("rnd mem_req", bus.mem_req, e_req);
      chk("rnd mem_we", bus.mem_we, e_we);
      chk("rnd mem_addr", bus.mem_addr, e_addr);
      chk("rnd mem_wdata", bus.mem_wdata, e_wd);
      chk("rnd ic_ack", bus.ic_ack, e_ia);
      chk("rnd dc_ack", bus.dc_ack, e_da);
      chk("rnd ic_rdata", bus.ic_rdata, e_ird);
      chk("rnd dc_rdata", bus.dc_rdata, e_drd);
      chk("rnd busy", busy, e_busy);
      chk("rnd conflict_cnt", cnt, m_cnt[CNT_W-1:0]);
      chk("rnd ack_exclusive", bus.ic_ack & bus.dc_ack, 1'b0);

      rst = ($urandom_range(0, 59) == 0);
      if (bus.ic_req && bus.ic_ack) bus.ic_req = 0;
      else if (!bus.ic_req && $urandom_range(0, 3) == 0) begin
        bus.ic_req = 1; bus.ic_addr = $urandom();
      end
      if (bus.dc_req && bus.dc_ack) bus.dc_req = 0;
      else if (!bus.dc_req && $urandom_range(0, 3) == 0) begin
        bus.dc_req = 1; bus.dc_we = 1'($urandom_range(0, 1));
        bus.dc_addr = $urandom(); bus.dc_wdata = rand_line();
      end
      if (bus.mem_ack) bus.mem_ack = 0;
      else if (bus.mem_req) begin
        if ($urandom_range(0, 1) == 1) begin bus.mem_ack = 1; bus.mem_rdata = rand_line(); end
      end else if ($urandom_range(0, 7) == 0) begin
        bus.mem_ack = 1; bus.mem_rdata = rand_line();
      end
    end

    // Continuous contention on a 3-bit counter: one increment per 3-cycle round
    srst = 1;
    @(negedge clk);
    srst = 0;
    repeat (10) @(negedge clk);
    chk("sat count after 4 rounds", scnt, 3'd4);
    repeat (30) @(negedge clk);
    chk("sat count saturated", scnt, 3'd7);
    repeat (30) @(negedge clk);
    chk("sat count no wrap", scnt, 3'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory line port between the instruction cache (line fills) and the data cache (line fills and write-backs).
- Sits between icache/dcache miss logic and the memory module.
- Serialises requests, alternates grants round-robin under contention, holds one transaction at a time, and returns read data and a one-cycle acknowledge to the owning cache.

Parameters:
- ADDR_W, 32, byte address width of all address ports.
- LINE_W, 128, cache line width in bits (4 x 32-bit words).
- CNT_W, 16, width of the contention counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ic_req  in  1  icache line-fill request; held until ic_ack.
- ic_addr  in  ADDR_W  icache line address; stable while ic_req.
- ic_rdata  out  LINE_W  fill data; valid only while ic_ack=1.
- ic_ack  out  1  one-cycle completion pulse to icache.
- dc_req  in  1  dcache request; held until dc_ack.
- dc_we  in  1  1 = write-back, 0 = fill; stable while dc_req.
- dc_addr  in  ADDR_W  dcache line address.
- dc_wdata  in  LINE_W  write-back line.
- dc_rdata  out  LINE_W  fill data; valid only while dc_ack=1.
- dc_ack  out  1  one-cycle completion pulse to dcache.
- mem_req  out  1  memory transaction request; held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory line address.
- mem_wdata  out  LINE_W  memory write data.
- mem_rdata  in  LINE_W  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion pulse.
- busy  out  1  1 whenever state != IDLE.
- conflict_cnt  out  CNT_W  saturating count of arbitration cycles with both requests pending.

Behaviour:
- Interface rule: one clock, clk; reset is synchronous and active-high, named reset.
- All outputs are registered.
- States: IDLE, GRANT_I, GRANT_D, RESP.
- Reset (at any time, including mid-transaction): state=IDLE, last_grant=I, conflict_cnt=0, and all outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, ic_ack, dc_ack, ic_rdata, dc_rdata, busy).
  - An in-flight transaction is abandoned; mem_req drops the next cycle.
  - Requesters reissue their requests.
- IDLE, sampling at each edge:
  - Only ic_req: go to GRANT_I.
  - Only dc_req: go to GRANT_D.
  - Both: grant the side that is not last_grant (after reset dcache wins first), and increment conflict_cnt, saturating at all-ones.
  - Neither: stay in IDLE.
- Entering a GRANT state:
  - Latch the owner's addr into mem_addr; set mem_req=1.
  - Owner is dcache: latch dc_we into mem_we and dc_wdata into mem_wdata.
  - Owner is icache: mem_we=0, mem_wdata=0.
  - Update last_grant.
- GRANT_x:
  - mem_req and the memory outputs stay constant until mem_ack is sampled high.
  - Requester inputs are not re-sampled.
  - On mem_ack: go to RESP, mem_req=0, mem_we=0, owner's ack=1, owner's rdata=mem_rdata.
  - For write-backs, dc_rdata is still loaded from mem_rdata (don't-care content).
- RESP: lasts one cycle; the ack drops to 0, rdata returns to 0, then go to IDLE.
  - The requester drops req at the edge after it sees ack, so IDLE never re-grants a completed request.
- Latency: req sampled at edge E0 -> mem_req high after E0. If mem_ack is sampled at edge Ek, the owner's ack is high for exactly the cycle after Ek. Minimum request-to-ack latency is 2 cycles.
- mem_ack while in IDLE or RESP is ignored, with no state change.
- A request arriving during a transaction waits; there is no preemption.
- The waiting side is guaranteed the next grant if it is still requesting in IDLE.
- busy=1 in GRANT_I, GRANT_D and RESP.
- ic_ack and dc_ack are never high in the same cycle.

Test Plan:
- Reset, then ic_req=1, ic_addr=0x40, memory acks 3 cycles after mem_req rises with mem_rdata=0xA..A -> mem_addr=0x40, mem_we=0; ic_ack high for exactly 1 cycle with ic_rdata=0xA..A; dc_ack stays 0; conflict_cnt=0.
- dc_req=1, dc_we=1, dc_addr=0x80, dc_wdata=0x1234 -> mem_we=1, mem_wdata=0x1234, mem_addr=0x80 held until mem_ack; dc_ack pulses once; busy returns to 0 two cycles after mem_ack.
- After reset, ic_req and dc_req asserted in the same cycle and held until acked:
  - dcache is served first, then icache.
  - conflict_cnt=1.
  - Repeating the contention gives icache first.
- mem_ack pulsed while in IDLE -> no ack output, state stays IDLE, mem_req stays 0.
- reset asserted while in GRANT_D, before mem_ack -> the next cycle mem_req=0, busy=0, no ack is issued; the reissued dc_req completes normally.
- Force conflict_cnt to all-ones (65535) via repeated contention -> it remains at 65535 and does not wrap to 0.
